stepper_step_gen: RTL

Fabric-side step pulse generator that sits at the far end of a stepper `steps` PIO. It consumes the 32-bit command word the HPS writes into the PIO's `out_port`, and drives the driver's STEP/DIR pins with a programmed pulse period and direction-setup delay. It returns a 32-bit status word for the same PIO's `in_port`, and a signed position word for a separate readback PIO. One instance per axis; single clock domain with the PIO.

---
 rtl/stepper_step_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/stepper_step_gen.sv
// Step/dir pulse generator driven by a tagged 32-bit PIO command word.
// One instance per axis; reports busy/tag/abort/remaining and a signed position.
//
// state | meaning
// IDLE  | waiting for a tag toggle; dir_out holds
// SETUP | DIR stable, waiting DIR_SETUP cycles before the first STEP rise
// HIGH  | STEP high for H cycles; position already moved on entry
// LOW   | STEP low for H cycles, then next pulse or back to IDLE
module stepper_step_gen #(
   parameter int DIR_SETUP = 2,
   parameter int MIN_HALF  = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] cmd_word,
   input  logic        abort,
   output logic        step_out,
   output logic        dir_out,
   output logic [31:0] status_word,
   output logic [31:0] position
);
   // A zero half-period would underflow the phase timer, so never go below 1.
   localparam int          MIN_EFF    = (MIN_HALF < 1) ? 1 : MIN_HALF;
   localparam logic [13:0] MIN_H      = 14'(MIN_EFF);
   localparam logic [13:0] SETUP_LOAD = (DIR_SETUP > 0) ? 14'(DIR_SETUP - 1) : 14'd0;

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

   state_t      state;
   logic [13:0] half;
   logic [13:0] timer;
   logic [15:0] remaining;
   logic        tag;
   logic        aborted;
   logic        abort_pend;

   logic [13:0] cmd_half;
   logic        cmd_new;
   logic        step_dir;
   logic [31:0] pos_step;

   assign cmd_half = (cmd_word[29:16] < MIN_H) ? MIN_H : cmd_word[29:16];
   assign cmd_new  = (cmd_word[30] != tag) && !abort;
   // With no setup delay the first pulse leaves IDLE before dir_out is latched.
   assign step_dir = (state == IDLE) ? cmd_word[31] : dir_out;
   assign pos_step = step_dir ? position + 32'd1 : position - 32'd1;

   assign status_word = {(state != IDLE), tag, aborted, 13'd0, remaining};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         step_out   <= 1'b0;
         dir_out    <= 1'b0;
         position   <= 32'd0;
         half       <= 14'd0;
         timer      <= 14'd0;
         remaining  <= 16'd0;
         tag        <= 1'b0;
         aborted    <= 1'b0;
         abort_pend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_new) begin
                  tag     <= cmd_word[30];
                  aborted <= 1'b0;
                  if (cmd_word[15:0] != 16'd0) begin
                     dir_out    <= cmd_word[31];
                     half       <= cmd_half;
                     remaining  <= cmd_word[15:0];
                     abort_pend <= 1'b0;
                     if (DIR_SETUP > 0) begin
                        state <= SETUP;
                        timer <= SETUP_LOAD;
                     end else begin
                        state    <= HIGH;
                        step_out <= 1'b1;
                        position <= pos_step;
                        timer    <= cmd_half - 14'd1;
                     end
                  end
               end
            end
            SETUP: begin
               if (abort) begin
                  state   <= IDLE;
                  aborted <= 1'b1;
               end else if (timer == 14'd0) begin
                  state    <= HIGH;
                  step_out <= 1'b1;
                  position <= pos_step;
                  timer    <= half - 14'd1;
               end else begin
                  timer <= timer - 14'd1;
               end
            end
            HIGH: begin
               // Abort is remembered so the pulse keeps its full width.
               if (timer == 14'd0) begin
                  step_out  <= 1'b0;
                  remaining <= remaining - 16'd1;
                  if (abort || abort_pend) begin
                     state   <= IDLE;
                     aborted <= 1'b1;
                  end else begin
                     state <= LOW;
                     timer <= half - 14'd1;
                  end
               end else begin
                  timer      <= timer - 14'd1;
                  abort_pend <= abort_pend | abort;
               end
            end
            LOW: begin
               if (abort) begin
                  state   <= IDLE;
                  aborted <= 1'b1;
               end else if (timer == 14'd0) begin
                  if (remaining != 16'd0) begin
                     state    <= HIGH;
                     step_out <= 1'b1;
                     position <= pos_step;
                     timer    <= half - 14'd1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  timer <= timer - 14'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
